// File: rtl/usr_serial_rx.sv
// Serial frame receiver for an LSB-first USR bit stream.
// Checks start/parity/stop and buffers good words behind valid/ready.
module usr_serial_rx #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SI,
    input  logic             bit_en,
    output logic [WIDTH-1:0] PO,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pmis_q, pmis_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [NW-1:0]    count_q;

    logic             push, pop, full;
    logic             perr_d, ferr_d, ovr_d;
    logic             perr_q, ferr_q, ovr_q;

    assign pop  = po_valid && po_ready;
    assign full = (count_q == NW'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            pmis_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            pmis_q  <= pmis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pmis_d  = pmis_q;
        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!SI) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_d = {SI, shift_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    pmis_d  = SI ^ (^shift_q);
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    always_comb begin
        push   = 1'b0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        ovr_d  = 1'b0;
        if (bit_en && state_q == STOP) begin
            if (!SI) begin
                ferr_d = 1'b1;
            end else if (pmis_q) begin
                perr_d = 1'b1;
            end else if (full && !pop) begin
                ovr_d = 1'b1;
            end else begin
                push = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            ovr_q  <= ovr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= shift_q;
                wptr_q        <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + NW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - NW'(1);
            end
        end
    end

    assign po_valid   = (count_q != '0);
    assign PO         = po_valid ? mem_q[rptr_q] : '0;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_usr_serial_rx.sv
// Scoreboard bench for usr_serial_rx: directed frames, queued
// expectations, and a monitor that checks every transfer and pulse.
module tb_usr_serial_rx;

    logic       clk;
    logic       rst;
    logic       SI;
    logic       bit_en;
    logic [4:0] PO;
    logic       po_valid;
    logic       po_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_data [$];
    logic [2:0] exp_err  [$];

    usr_serial_rx #(.WIDTH(5), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .SI        (SI),
        .bit_en    (bit_en),
        .PO        (PO),
        .po_valid  (po_valid),
        .po_ready  (po_ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected words on transfers, expected codes on pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (po_valid && po_ready) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %b expected none", PO);
                end else begin
                    chk("po_word", 32'(PO), 32'(exp_data.pop_front()));
                end
            end
            if ({overrun, frame_err, parity_err} != 3'b000) begin
                if (exp_err.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got %b expected none",
                             {overrun, frame_err, parity_err});
                end else begin
                    chk("err_pulse", 32'({overrun, frame_err, parity_err}),
                        32'(exp_err.pop_front()));
                end
            end
        end
    end

    task automatic send_bit(input logic b, input logic rdy);
        repeat (3) @(posedge clk);
        #1;
        SI     = b;
        bit_en = 1'b1;
        if (rdy) po_ready = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        SI     = 1'b1;
    endtask

    task automatic send_frame(input logic [4:0] w, input logic pflip,
                              input logic stop, input logic rdy_stop);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send_bit(w[i], 1'b0);
        end
        send_bit((^w) ^ pflip, 1'b0);
        send_bit(stop, rdy_stop);
    endtask

    task automatic drain();
        bit done;
        done     = 1'b0;
        po_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!po_valid) begin
                done = 1'b1;
                break;
            end
        end
        po_ready = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got po_valid=1 expected 0");
        end
    endtask

    initial begin
        rst      = 1'b1;
        SI       = 1'b1;
        bit_en   = 1'b0;
        po_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 32'(po_valid), 32'd0);
        chk("reset_po", 32'(PO), 32'd0);
        chk("reset_pulses", 32'({overrun, frame_err, parity_err}), 32'd0);

        // Good frame: SI = 0,1,0,1,0,1,1,1
        send_frame(5'b10101, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("good_valid", 32'(po_valid), 32'd1);
        chk("good_po", 32'(PO), 32'b10101);
        exp_data.push_back(5'b10101);
        drain();

        // Parity bit forced to 0
        exp_err.push_back(3'b001);
        send_frame(5'b10101, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("perr_valid", 32'(po_valid), 32'd0);

        // Framing error must leave the buffered word alone
        send_frame(5'b01110, 1'b0, 1'b1, 1'b0);
        exp_err.push_back(3'b010);
        send_frame(5'b00011, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("ferr_valid", 32'(po_valid), 32'd1);
        chk("ferr_po", 32'(PO), 32'b01110);
        exp_data.push_back(5'b01110);
        drain();
        chk("ferr_empty", 32'(po_valid), 32'd0);

        // Overrun on third frame, then ordered readout
        send_frame(5'b00001, 1'b0, 1'b1, 1'b0);
        send_frame(5'b00010, 1'b0, 1'b1, 1'b0);
        exp_err.push_back(3'b100);
        send_frame(5'b00100, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("ovr_head", 32'(PO), 32'b00001);
        exp_data.push_back(5'b00001);
        exp_data.push_back(5'b00010);
        drain();
        chk("ovr_empty", 32'(po_valid), 32'd0);

        // Full buffer, pop coincides with the third push
        exp_data.push_back(5'b00101);
        exp_data.push_back(5'b01001);
        exp_data.push_back(5'b10001);
        send_frame(5'b00101, 1'b0, 1'b1, 1'b0);
        send_frame(5'b01001, 1'b0, 1'b1, 1'b0);
        send_frame(5'b10001, 1'b0, 1'b1, 1'b1);
        drain();
        chk("pp_empty", 32'(po_valid), 32'd0);
        chk("pp_all_read", 32'(exp_data.size()), 32'd0);

        // Async reset mid-frame with a word buffered
        send_frame(5'b00111, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", 32'(po_valid), 32'd1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(po_valid), 32'd0);
        chk("rst_po", 32'(PO), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(5'b11111, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("post_rst_po", 32'(PO), 32'b11111);
        exp_data.push_back(5'b11111);
        drain();

        repeat (4) @(negedge clk);
        chk("data_queue_empty", 32'(exp_data.size()), 32'd0);
        chk("err_queue_empty", 32'(exp_err.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
